board_reader: RTL
=================

Name: board_reader

Overview:
- Consumer end of the Buscaminas 8x8 board bus: snapshots the 9-bit-per-cell board on request and streams it cell by cell, row-major, over a valid/ready interface to the display/VGA tile renderer.
- Decodes each cell into a 4-bit glyph index.
- Accumulates per-frame game statistics (revealed, flagged, bombs) and publishes win/lose status once the whole frame has been streamed.

Parameters:
- N, 8, board dimension (N x N cells).
- CELL_W, 9, cell word width.
- CNT_W, $clog2(N*N+1), width of all cell counters.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- board_in  input  CELL_W x [0:N-1][0:N-1]  board from the game core.
- start  input  1  frame request pulse.
- busy  output  1  high in SCAN or DONE.
- out_valid  output  1  cell token valid.
- out_ready  input  1  renderer accepts token.
- out_row  output  $clog2(N)  token row.
- out_col  output  $clog2(N)  token column.
- out_glyph  output  4  decoded glyph.
- out_cursor  output  1  cell bit7.
- out_last  output  1  final token of frame.
- done  output  1  one-cycle frame-complete pulse.
- revealed_cnt  output  CNT_W  revealed non-bomb cells, last frame.
- flag_cnt  output  CNT_W  flagged cells, last frame.
- win  output  1  game status, last frame.
- lose  output  1  game status, last frame.

Behaviour:
- Cell encoding (fixed):
  - [3:0] adjacent-bomb count.
  - [4] bomb.
  - [5] revealed.
  - [6] flagged.
  - [7] cursor.
  - [8] reserved, ignored.
- Glyph decode, first match wins:
  - !revealed & flagged -> 10.
  - !revealed -> 9.
  - revealed & bomb -> 11.
  - revealed & count<=8 -> count.
  - otherwise -> 12 (error glyph).
- Reset (rst=0, async): state IDLE, index 0. All outputs 0; counters, win and lose cleared.
- FSM states: IDLE, SCAN, DONE.
  - IDLE: start=1 at a clk edge copies board_in into the internal snapshot, clears the accumulators, index=0, and moves to SCAN. Latency: out_valid is high on the first cycle after the start edge.
  - SCAN:
    - out_valid=1.
    - Token fields come from snapshot[index]: row = index/N, col = index%N.
    - A transfer occurs when out_valid & out_ready at a clk edge; index then increments.
    - While out_ready=0, all token fields are held stable.
    - out_last=1 iff index == N*N-1.
    - A transfer with out_last moves to DONE.
  - DONE: lasts exactly one cycle.
    - done=1, out_valid=0.
    - revealed_cnt, flag_cnt, win and lose are loaded from the accumulators and held until the next DONE.
    - Next state is IDLE.
- Accumulators (updated on each transfer):
  - acc_rev += revealed & !bomb.
  - acc_flag += flagged & !revealed.
  - acc_bomb += bomb.
  - acc_hit |= revealed & bomb.
- Status at DONE:
  - lose = acc_hit.
  - win = !acc_hit & (acc_rev == N*N - acc_bomb).
  - A board with zero bombs and every cell revealed gives win=1.
- start while busy is ignored, and no re-snapshot happens. start and out_ready are independent; start asserted in the DONE cycle is ignored.
- board_in changes during SCAN have no effect on the tokens (snapshot only).
- Reset asserted mid-SCAN aborts the frame: no done pulse, and status is cleared to 0.
- Counter widths: CNT_W holds N*N = 64 without overflow; index wraps only via the return to IDLE.

Optional Feature:
- Macro DEBUG_REVEAL_EN.
- Defined: glyph decode treats every cell as revealed for glyph purposes only; a hidden bomb shows 11 and a hidden number shows its count. Flags are not displayed. Counters and win/lose are unaffected.
- Undefined: decode exactly as in Behaviour.

Test Plan:
- Empty board (all 0), start, out_ready=1 -> tokens on 64 consecutive cycles, all glyph 9, out_last only at (7,7); done 1 cycle later; revealed_cnt=0, flag_cnt=0, win=0, lose=0.
- Cell (2,3)=9'h023 (revealed, count 3), (0,0)=9'h040 (flagged), (7,7)=9'h010 (hidden bomb) -> glyphs 3, 10 and 9 at those positions; flag_cnt=1; revealed_cnt=1.
- Backpressure: out_ready toggles 1,0,0,1 from token 0 -> index 1 held stable with identical row/col/glyph for 3 cycles; 64 transfers total; done exactly once.
- Win: one bomb at (4,4) hidden and all 63 others revealed with valid counts -> revealed_cnt=63, win=1, lose=0. Setting (4,4)=9'h030 instead -> lose=1, win=0.
- Robustness: start pulsed at transfer 10 and during DONE -> ignored. board_in rewritten mid-scan -> tokens match the original snapshot. rst=0 at transfer 20 -> out_valid=0 asynchronously, no done pulse, status 0.
- With DEBUG_REVEAL_EN defined: hidden bomb 9'h010 -> glyph 11; hidden 9'h002 -> glyph 2; flagged 9'h040 -> glyph 0; flag_cnt still 1.

Source files
------------

// File: rtl/board_reader_if.sv
// Cell-token stream from board_reader to the tile renderer: valid/ready plus row, col, glyph, cursor and last.
// The master drives the token fields and valid; the slave drives ready.
interface board_reader_if #(
    parameter int N = 8
);
    localparam int RW = (N > 1) ? $clog2(N) : 1;

    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_row;
    logic [RW-1:0] out_col;
    logic [3:0]    out_glyph;
    logic          out_cursor;
    logic          out_last;

    modport master (
        output out_valid, out_row, out_col, out_glyph, out_cursor, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_row, out_col, out_glyph, out_cursor, out_last,
        output out_ready
    );
endinterface

// File: rtl/board_reader.sv
// Snapshots the NxN board on start, streams decoded cell tokens row-major, then publishes frame statistics.
// Latency: first token valid the cycle after the start edge; done pulses the cycle after the last transfer.
// Backpressure: token fields hold while out_ready is low. Build option DEBUG_REVEAL_EN decodes every cell as revealed.
module board_reader #(
    parameter int N      = 8,
    parameter int CELL_W = 9,
    parameter int CNT_W  = $clog2(N*N+1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [0:N-1][0:N-1][CELL_W-1:0] board_in,
    input  logic                            start,
    output logic                            busy,
    board_reader_if.master                  tok,
    output logic                            done,
    output logic [CNT_W-1:0]                revealed_cnt,
    output logic [CNT_W-1:0]                flag_cnt,
    output logic                            win,
    output logic                            lose
);
    localparam int              RW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [RW-1:0]   LAST_IDX = RW'(N-1);
    localparam logic [CNT_W:0]  TOTAL    = (CNT_W+1)'(N*N);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                          state;
    logic [0:N-1][0:N-1][CELL_W-1:0] snap;
    logic [RW-1:0]                   row, col, nrow, ncol;
    logic [3:0]                      glyph;
    logic                            cursor, last, valid;
    logic [CNT_W-1:0]                acc_rev, acc_flag, acc_bomb;
    logic                            acc_hit;
    logic [CNT_W-1:0]                rev_nxt, flag_nxt, bomb_nxt;
    logic                            hit_nxt, win_nxt;
    logic                            c_bomb, c_rev, c_flag;

    function automatic logic [3:0] glyph_of(input logic [6:0] c);
        logic shown;
        shown = c[5];
`ifdef DEBUG_REVEAL_EN
        shown = c[5] | 1'b1;
`endif
        if (!shown && c[6]) return 4'd10;
        if (!shown)         return 4'd9;
        if (c[4])           return 4'd11;
        if (c[3:0] <= 4'd8) return c[3:0];
        return 4'd12;
    endfunction

    always_comb begin
        ncol = col + 1'b1;
        nrow = row;
        if (col == LAST_IDX) begin
            ncol = '0;
            nrow = row + 1'b1;
        end
    end

    assign c_bomb = snap[row][col][4];
    assign c_rev  = snap[row][col][5];
    assign c_flag = snap[row][col][6];

    // Accumulators including the cell being transferred this cycle.
    assign rev_nxt  = acc_rev  + CNT_W'(c_rev & ~c_bomb);
    assign flag_nxt = acc_flag + CNT_W'(c_flag & ~c_rev);
    assign bomb_nxt = acc_bomb + CNT_W'(c_bomb);
    assign hit_nxt  = acc_hit | (c_rev & c_bomb);
    assign win_nxt  = ~hit_nxt & (({1'b0, rev_nxt} + {1'b0, bomb_nxt}) == TOTAL);

    assign tok.out_valid  = valid;
    assign tok.out_row    = row;
    assign tok.out_col    = col;
    assign tok.out_glyph  = glyph;
    assign tok.out_cursor = cursor;
    assign tok.out_last   = last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            snap         <= '0;
            row          <= '0;
            col          <= '0;
            glyph        <= '0;
            cursor       <= 1'b0;
            last         <= 1'b0;
            valid        <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            acc_rev      <= '0;
            acc_flag     <= '0;
            acc_bomb     <= '0;
            acc_hit      <= 1'b0;
            revealed_cnt <= '0;
            flag_cnt     <= '0;
            win          <= 1'b0;
            lose         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        snap     <= board_in;
                        row      <= '0;
                        col      <= '0;
                        glyph    <= glyph_of(board_in[0][0][6:0]);
                        cursor   <= board_in[0][0][7];
                        last     <= (N == 1);
                        valid    <= 1'b1;
                        busy     <= 1'b1;
                        acc_rev  <= '0;
                        acc_flag <= '0;
                        acc_bomb <= '0;
                        acc_hit  <= 1'b0;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (tok.out_ready) begin
                        acc_rev  <= rev_nxt;
                        acc_flag <= flag_nxt;
                        acc_bomb <= bomb_nxt;
                        acc_hit  <= hit_nxt;
                        if (last) begin
                            // Status lands with the done pulse so the consumer can sample both together.
                            revealed_cnt <= rev_nxt;
                            flag_cnt     <= flag_nxt;
                            win          <= win_nxt;
                            lose         <= hit_nxt;
                            valid        <= 1'b0;
                            last         <= 1'b0;
                            done         <= 1'b1;
                            state        <= DONE;
                        end else begin
                            row    <= nrow;
                            col    <= ncol;
                            glyph  <= glyph_of(snap[nrow][ncol][6:0]);
                            cursor <= snap[nrow][ncol][7];
                            last   <= (nrow == LAST_IDX) && (ncol == LAST_IDX);
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
